// File: rtl/pq_prime_ctrl.sv
// Prime-pair search controller: pops odd candidates from a FIFO, runs MR_ROUNDS engine rounds
// on each, and returns two distinct accepted primes. Engine watchdog: define PQ_CTRL_TIMEOUT_EN.
module pq_prime_ctrl #(
    parameter int unsigned NUM_BITS    = 128,
    parameter int unsigned MR_ROUNDS   = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                start,
    input  logic                pq_fifo_empty,
    input  logic [NUM_BITS-1:0] pq_fifo_dout,
    output logic                pq_fifo_rd_en,
    output logic                eng_start,
    output logic [NUM_BITS-1:0] eng_cand,
    output logic [3:0]          eng_round,
    input  logic                eng_done,
    input  logic                eng_pass,
    output logic [NUM_BITS-1:0] p_out,
    output logic [NUM_BITS-1:0] q_out,
    output logic                pq_valid,
    output logic                busy,
    output logic                err_timeout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] ISSUE  = 3'd3;
    localparam logic [2:0] WAIT   = 3'd4;
    localparam logic [2:0] DECIDE = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [3:0] LAST_ROUND = 4'(MR_ROUNDS - 1);

    if (MR_ROUNDS < 1 || MR_ROUNDS > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_bad_param
        $error("pq_prime_ctrl: MR_ROUNDS or TIMEOUT_CYC out of range");
    end

    logic [2:0]          state_q, state_d;
    logic [NUM_BITS-1:0] cand_q, cand_d;
    logic [NUM_BITS-1:0] p_q, p_d;
    logic [NUM_BITS-1:0] q_q, q_d;
    logic [3:0]          round_q, round_d;
    logic                valid_q, valid_d;
    logic                found_q, found_d;
    logic                pass_q, pass_d;

`ifdef PQ_CTRL_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC - 1);
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        p_d     = p_q;
        q_d     = q_q;
        round_d = round_q;
        valid_d = valid_q;
        found_d = found_q;
        pass_d  = pass_q;
`ifdef PQ_CTRL_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    valid_d = 1'b0;
                    p_d     = '0;
                    q_d     = '0;
                    found_d = 1'b0;
                end
            end
            FETCH: begin
                if (!pq_fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                cand_d = pq_fifo_dout;
                // Even values can never be prime here; drop them without touching the engine.
                if (!pq_fifo_dout[0]) begin
                    state_d = FETCH;
                end else begin
                    round_d = 4'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef PQ_CTRL_TIMEOUT_EN
                wcnt_d  = 16'd0;
`endif
            end
            WAIT: begin
                if (eng_done) begin
                    pass_d  = eng_pass;
                    state_d = DECIDE;
                end
`ifdef PQ_CTRL_TIMEOUT_EN
                else if (wcnt_q == TIMEOUT_LIM) begin
                    state_d = FETCH;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
`endif
            end
            DECIDE: begin
                if (!pass_q) begin
                    state_d = FETCH;
                end else if (round_q != LAST_ROUND) begin
                    round_d = round_q + 4'd1;
                    state_d = ISSUE;
                end else if (!found_q) begin
                    p_d     = cand_q;
                    found_d = 1'b1;
                    state_d = FETCH;
                end else if (cand_q == p_q) begin
                    state_d = FETCH;
                end else begin
                    q_d     = cand_q;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            cand_q  <= '0;
            p_q     <= '0;
            q_q     <= '0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            found_q <= 1'b0;
            pass_q  <= 1'b0;
`ifdef PQ_CTRL_TIMEOUT_EN
            wcnt_q  <= 16'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            p_q     <= p_d;
            q_q     <= q_d;
            round_q <= round_d;
            valid_q <= valid_d;
            found_q <= found_d;
            pass_q  <= pass_d;
`ifdef PQ_CTRL_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign pq_fifo_rd_en = (state_q == FETCH) && !pq_fifo_empty;
    assign eng_start     = (state_q == ISSUE);
    assign eng_cand      = cand_q;
    assign eng_round     = round_q;
    assign p_out         = p_q;
    assign q_out         = q_q;
    assign pq_valid      = valid_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
`ifdef PQ_CTRL_TIMEOUT_EN
    assign err_timeout   = err_q;
`else
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_pq_prime_ctrl.sv
// Self-checking bench for pq_prime_ctrl: FIFO and engine models plus a list-level search model.
module tb_pq_prime_ctrl;
    localparam int NB = 32;
    localparam int MR = 4;
    localparam int TO = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b1;
    logic          start = 1'b0;
    logic          pq_fifo_empty;
    logic [NB-1:0] pq_fifo_dout = '0;
    logic          pq_fifo_rd_en;
    logic          eng_start;
    logic [NB-1:0] eng_cand;
    logic [3:0]    eng_round;
    logic          eng_done = 1'b0;
    logic          eng_pass = 1'b0;
    logic [NB-1:0] p_out, q_out;
    logic          pq_valid, busy, err_timeout;

    int checks = 0;
    int failures = 0;

    pq_prime_ctrl #(.NUM_BITS(NB), .MR_ROUNDS(MR), .TIMEOUT_CYC(TO)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .pq_fifo_empty(pq_fifo_empty), .pq_fifo_dout(pq_fifo_dout),
        .pq_fifo_rd_en(pq_fifo_rd_en), .eng_start(eng_start), .eng_cand(eng_cand),
        .eng_round(eng_round), .eng_done(eng_done), .eng_pass(eng_pass),
        .p_out(p_out), .q_out(q_out), .pq_valid(pq_valid), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 aclk = ~aclk;

    // FIFO model: data appears the cycle after the pop strobe.
    logic [NB-1:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit fifo_flush = 1'b0;
    int n_pop = 0;
    assign pq_fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge aclk) begin
        if (fifo_flush) rd_ptr <= wr_ptr;
        else if (pq_fifo_rd_en) begin
            pq_fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            n_pop <= n_pop + 1;
        end
    end

    // Engine model: verdict policy below, random 1..4 cycle latency, optional silence.
    logic [NB-1:0] fail_cand = '0;
    int            fail_round = -1;
    logic [NB-1:0] silent_cand = '0;
    bit            silent_en = 1'b0;
    bit            rand_fail_en = 1'b0;
    int unsigned   salt = 0;
    int            eng_timer = 0;
    logic          pend_pass = 1'b0;
    int            n_start = 0;
    int            n_start_even = 0;
    int            n_start_fc = 0;

    function automatic bit eng_verdict(input logic [NB-1:0] c, input int r);
        int unsigned h;
        if (c == fail_cand && r == fail_round) return 1'b0;
        h = (32'(c) ^ salt) + 32'(r) * 32'h9E3779B1;
        if (rand_fail_en && (h % 7) == 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            eng_done <= 1'b0;
            eng_pass <= 1'b0;
            eng_timer <= 0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                n_start <= n_start + 1;
                if (!eng_cand[0]) n_start_even <= n_start_even + 1;
                if (eng_cand == fail_cand) n_start_fc <= n_start_fc + 1;
                pend_pass <= eng_verdict(eng_cand, int'(eng_round));
                eng_timer <= (silent_en && eng_cand == silent_cand) ? 0
                                                                    : int'($urandom_range(1, 4));
            end else if (eng_timer == 1) begin
                eng_done <= 1'b1;
                eng_pass <= pend_pass;
                eng_timer <= 0;
            end else if (eng_timer > 1) begin
                eng_timer <= eng_timer - 1;
            end
        end
    end

    // List-level reference: what a correct search yields for cand_list.
    logic [NB-1:0] cand_list[$];
    task automatic model_search(output logic [NB-1:0] ep, output logic [NB-1:0] eq,
                                output bit ev, output int es, output int epops);
        bit found;
        logic [NB-1:0] c;
        bit ok;
        found = 0; ep = '0; eq = '0; ev = 0; es = 0; epops = 0;
        foreach (cand_list[i]) begin
            c = cand_list[i];
            ok = 1;
            epops++;
            if (c[0]) begin
                for (int r = 0; r < MR; r++) begin
                    es++;
                    if (!eng_verdict(c, r)) begin ok = 0; break; end
                end
                if (ok) begin
                    if (!found) begin ep = c; found = 1; end
                    else if (c != ep) begin eq = c; ev = 1; return; end
                end
            end
        end
    endtask

    task automatic push_list();
        foreach (cand_list[i]) begin
            fifo_mem[wr_ptr] = cand_list[i];
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0; start = 1'b0; fifo_flush = 1'b1;
        repeat (2) @(negedge aclk);
        fifo_flush = 1'b0; aresetn = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge aclk);
            if (pq_valid === 1'b1) begin ok = 1; return; end
        end
    endtask

    task automatic wait_issue(input logic [NB-1:0] c, output bit ok);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge aclk);
            if (eng_start === 1'b1 && eng_cand === c) begin ok = 1; return; end
        end
    endtask

    task automatic test_reset();
        #1 aresetn = 1'b0;
        @(negedge aclk);
        checks += 5;
        if ({pq_fifo_rd_en, eng_start, busy, pq_valid, err_timeout} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000",
                                 {pq_fifo_rd_en, eng_start, busy, pq_valid, err_timeout});
        end
        if (eng_cand !== '0) begin failures++; $display("FAIL reset_cand: got %0h want 0", eng_cand); end
        if (eng_round !== 4'd0) begin failures++; $display("FAIL reset_round: got %0d want 0", eng_round); end
        if (p_out !== '0) begin failures++; $display("FAIL reset_p: got %0h want 0", p_out); end
        if (q_out !== '0) begin failures++; $display("FAIL reset_q: got %0h want 0", q_out); end
        @(negedge aclk); aresetn = 1'b1;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            checks += 2;
            if (busy !== 1'b1) begin failures++; $display("FAIL empty_busy: cyc %0d got %b want 1", i, busy); end
            if (pq_fifo_rd_en !== 1'b0) begin failures++; $display("FAIL empty_rd_en: cyc %0d got %b want 0", i, pq_fifo_rd_en); end
            @(negedge aclk);
        end
    endtask

    task automatic test_skip_even();
        int s0, p0, e0;
        bit ok;
        do_reset();
        cand_list = '{32'd10, 32'd13, 32'd17};
        push_list();
        s0 = n_start; p0 = n_pop; e0 = n_start_even;
        pulse_start();
        wait_valid(1000, ok);
        checks += 6;
        if (!ok) begin failures++; $display("FAIL skip_even_done: got valid=%b want 1", pq_valid); end
        if (p_out !== 32'd13) begin failures++; $display("FAIL skip_even_p: got %0d want 13", p_out); end
        if (q_out !== 32'd17) begin failures++; $display("FAIL skip_even_q: got %0d want 17", q_out); end
        if (n_start - s0 != 8) begin failures++; $display("FAIL skip_even_starts: got %0d want 8", n_start - s0); end
        if (n_start_even != e0) begin failures++; $display("FAIL skip_even_even_issue: got %0d want 0", n_start_even - e0); end
        if (n_pop - p0 != 3) begin failures++; $display("FAIL skip_even_pops: got %0d want 3", n_pop - p0); end
        repeat (5) @(negedge aclk);
        checks += 2;
        if ({pq_valid, busy} !== 2'b10) begin failures++; $display("FAIL done_hold_flags: got %b want 10", {pq_valid, busy}); end
        if (p_out !== 32'd13 || q_out !== 32'd17) begin
            failures++; $display("FAIL done_hold_pq: got %0d/%0d want 13/17", p_out, q_out);
        end
    endtask

    task automatic test_dup_reject();
        int s0, p0, f0;
        bit ok;
        do_reset();
        fail_cand = 32'd15; fail_round = 2;
        cand_list = '{32'd15, 32'd13, 32'd13, 32'd19};
        push_list();
        s0 = n_start; p0 = n_pop; f0 = n_start_fc;
        pulse_start();
        wait_valid(1500, ok);
        checks += 6;
        if (!ok) begin failures++; $display("FAIL dup_done: got valid=%b want 1", pq_valid); end
        if (p_out !== 32'd13) begin failures++; $display("FAIL dup_p: got %0d want 13", p_out); end
        if (q_out !== 32'd19) begin failures++; $display("FAIL dup_q: got %0d want 19", q_out); end
        if (n_start_fc - f0 != 3) begin failures++; $display("FAIL dup_rounds15: got %0d want 3", n_start_fc - f0); end
        if (n_start - s0 != 15) begin failures++; $display("FAIL dup_starts: got %0d want 15", n_start - s0); end
        if (n_pop - p0 != 4) begin failures++; $display("FAIL dup_pops: got %0d want 4", n_pop - p0); end
        fail_cand = '0; fail_round = -1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        silent_en = 1'b1; silent_cand = 32'd23;
        cand_list = '{32'd21, 32'd23, 32'd25};
        push_list();
        pulse_start();
        wait_issue(32'd23, ok);
        repeat (3) @(negedge aclk);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL mid_issue23: got no issue want issue"); end
        if (busy !== 1'b1 || p_out !== 32'd21) begin
            failures++; $display("FAIL mid_pre_state: got busy=%b p=%0d want 1/21", busy, p_out);
        end
        #2 aresetn = 1'b0; fifo_flush = 1'b1;
        #1;
        checks += 3;
        if ({busy, pq_valid, pq_fifo_rd_en, eng_start, err_timeout} !== 5'b0) begin
            failures++; $display("FAIL mid_rst_flags: got %b want 00000",
                                 {busy, pq_valid, pq_fifo_rd_en, eng_start, err_timeout});
        end
        if (p_out !== '0 || q_out !== '0) begin failures++; $display("FAIL mid_rst_pq: got %0h/%0h want 0/0", p_out, q_out); end
        if (eng_cand !== '0 || eng_round !== 4'd0) begin
            failures++; $display("FAIL mid_rst_eng: got %0h/%0d want 0/0", eng_cand, eng_round);
        end
        @(negedge aclk); @(negedge aclk);
        fifo_flush = 1'b0; aresetn = 1'b1; silent_en = 1'b0;
        cand_list = '{32'd29, 32'd31};
        push_list();
        pulse_start();
        wait_valid(1000, ok);
        checks += 1;
        if (!ok || p_out !== 32'd29 || q_out !== 32'd31) begin
            failures++; $display("FAIL mid_restart: got v=%b p=%0d q=%0d want 1/29/31", pq_valid, p_out, q_out);
        end
    endtask

    task automatic test_start_ignored();
        int s0, p0;
        bit ok;
        do_reset();
        cand_list = '{32'd33, 32'd35};
        push_list();
        s0 = n_start; p0 = n_pop;
        pulse_start();
        wait_issue(32'd33, ok);
        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0;
        wait_valid(1000, ok);
        checks += 3;
        if (!ok || p_out !== 32'd33 || q_out !== 32'd35) begin
            failures++; $display("FAIL wait_start_pq: got v=%b p=%0d q=%0d want 1/33/35", pq_valid, p_out, q_out);
        end
        if (n_pop - p0 != 2) begin failures++; $display("FAIL wait_start_pops: got %0d want 2", n_pop - p0); end
        if (n_start - s0 != 8) begin failures++; $display("FAIL wait_start_starts: got %0d want 8", n_start - s0); end
        cand_list = '{32'd37, 32'd39};
        push_list();
        pulse_start();
        checks += 2;
        if ({pq_valid, busy} !== 2'b01) begin failures++; $display("FAIL done_restart_flags: got %b want 01", {pq_valid, busy}); end
        if (p_out !== '0 || q_out !== '0) begin failures++; $display("FAIL done_restart_clear: got %0d/%0d want 0/0", p_out, q_out); end
        wait_valid(1000, ok);
        checks += 1;
        if (!ok || p_out !== 32'd37 || q_out !== 32'd39) begin
            failures++; $display("FAIL done_restart_pq: got v=%b p=%0d q=%0d want 1/37/39", pq_valid, p_out, q_out);
        end
    endtask

`ifdef PQ_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        silent_en = 1'b1; silent_cand = 32'd41;
        cand_list = '{32'd41, 32'd43, 32'd45};
        push_list();
        pulse_start();
        wait_issue(32'd41, ok);
        checks += 1;
        if (!ok) begin failures++; $display("FAIL to_issue41: got no issue want issue"); end
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            checks += 1;
            if (err_timeout !== 1'b0 || pq_fifo_rd_en !== 1'b0) begin
                failures++; $display("FAIL to_early: cyc %0d got err=%b rd=%b want 0/0", i, err_timeout, pq_fifo_rd_en);
            end
        end
        @(negedge aclk);
        checks += 1;
        if (err_timeout !== 1'b1 || pq_fifo_rd_en !== 1'b1) begin
            failures++; $display("FAIL to_fire: got err=%b rd=%b want 1/1", err_timeout, pq_fifo_rd_en);
        end
        wait_valid(1000, ok);
        checks += 2;
        if (!ok || p_out !== 32'd43 || q_out !== 32'd45) begin
            failures++; $display("FAIL to_next: got v=%b p=%0d q=%0d want 1/43/45", pq_valid, p_out, q_out);
        end
        if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b want 1", err_timeout); end
        silent_en = 1'b0;
        do_reset();
        checks += 1;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_reset_clear: got %b want 0", err_timeout); end
    endtask
`else
    task automatic test_timeout();
        int p0;
        bit ok;
        do_reset();
        silent_en = 1'b1; silent_cand = 32'd41;
        cand_list = '{32'd41, 32'd43};
        push_list();
        p0 = n_pop;
        pulse_start();
        wait_issue(32'd41, ok);
        repeat (200) @(negedge aclk);
        checks += 2;
        if (!ok || busy !== 1'b1 || n_pop - p0 != 1) begin
            failures++; $display("FAIL nto_wait: got issue=%b busy=%b pops=%0d want 1/1/1", ok, busy, n_pop - p0);
        end
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL nto_err: got %b want 0", err_timeout); end
        silent_en = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [NB-1:0] ep, eq, v;
        bit ev, ok;
        int es, epops, s0, p0, len;
        rand_fail_en = 1'b1;
        for (int it = 0; it < 8; it++) begin
            do_reset();
            salt = $urandom;
            len = int'($urandom_range(4, 10));
            cand_list = {};
            for (int k = 0; k < len; k++) begin
                if (k > 0 && $urandom_range(0, 3) == 0) v = cand_list[$urandom_range(0, k - 1)];
                else begin
                    v = $urandom;
                    v[0] = ($urandom_range(0, 2) != 0);
                end
                cand_list.push_back(v);
            end
            model_search(ep, eq, ev, es, epops);
            push_list();
            s0 = n_start; p0 = n_pop;
            pulse_start();
            if (ev) begin
                wait_valid(3000, ok);
                checks += 1;
                if (!ok || p_out !== ep || q_out !== eq) begin
                    failures++; $display("FAIL rand_pq: it %0d got v=%b p=%0h q=%0h want 1/%0h/%0h",
                                         it, pq_valid, p_out, q_out, ep, eq);
                end
            end else begin
                for (int i = 0; i < 3000 && !pq_fifo_empty; i++) @(negedge aclk);
                repeat (80) @(negedge aclk);
                checks += 1;
                if ({pq_valid, busy} !== 2'b01) begin
                    failures++; $display("FAIL rand_nopair: it %0d got %b want 01", it, {pq_valid, busy});
                end
            end
            checks += 3;
            if (n_start - s0 != es) begin failures++; $display("FAIL rand_starts: it %0d got %0d want %0d", it, n_start - s0, es); end
            if (n_pop - p0 != epops) begin failures++; $display("FAIL rand_pops: it %0d got %0d want %0d", it, n_pop - p0, epops); end
            if (err_timeout !== 1'b0) begin failures++; $display("FAIL rand_err: it %0d got %b want 0", it, err_timeout); end
        end
        rand_fail_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        test_reset();
        test_skip_even();
        test_dup_reject();
        test_reset_mid();
        test_start_ignored();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pq_prime_ctrl.md
PQ_PRIME_CTRL -- requirements
Module: pq_prime_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 128: candidate width.
REQ-002 SHALL have parameter MR_ROUNDS, default 4: engine rounds per candidate (1..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: engine watchdog limit in cycles (1..65535).
REQ-004 SHALL have port aclk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port aresetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a p/q search.
REQ-007 SHALL have port pq_fifo_empty  in  1  candidate FIFO empty.
REQ-008 SHALL have port pq_fifo_dout  in  NUM_BITS  FIFO read data, valid the cycle after rd_en.
REQ-009 SHALL have port pq_fifo_rd_en  out  1  FIFO pop strobe.
REQ-010 SHALL have port eng_start  out  1  one-cycle pulse that launches one engine round.
REQ-011 SHALL have port eng_cand  out  NUM_BITS  candidate under test; held stable during a round.
REQ-012 SHALL have port eng_round  out  4  current round index, 0-based.
REQ-013 SHALL have port eng_done  in  1  one-cycle round-complete pulse.
REQ-014 SHALL have port eng_pass  in  1  round verdict, qualified by eng_done.
REQ-015 SHALL have port p_out, q_out  out  NUM_BITS  accepted primes.
REQ-016 SHALL have port pq_valid  out  1  p_out and q_out are both valid.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE and DONE.
REQ-018 SHALL have port err_timeout  out  1  sticky watchdog flag.

Function
REQ-019 SHALL implement the states IDLE, FETCH, LOAD, ISSUE, WAIT, DECIDE and DONE.
REQ-020 IDLE/DONE: start -> FETCH, clearing pq_valid, p_out, q_out and the found count; start in any other state SHALL be ignored.
REQ-021 FETCH: pq_fifo_rd_en SHALL be asserted (combinationally) only when pq_fifo_empty is 0, moving to LOAD; while the FIFO is empty the block SHALL stay in FETCH with rd_en 0.
REQ-022 LOAD: pq_fifo_dout SHALL be captured into eng_cand; if bit0 is 0 (even), the candidate SHALL be discarded -> FETCH with no engine issue, else round index = 0 -> ISSUE.
REQ-023 ISSUE: eng_start SHALL be high for exactly one cycle -> WAIT.
REQ-024 WAIT: on eng_done -> DECIDE, latching eng_pass.
REQ-025 DECIDE, pass=0: candidate discarded -> FETCH.
REQ-026 DECIDE, pass=1 and round < MR_ROUNDS-1: round index + 1 -> ISSUE.
REQ-027 DECIDE, pass=1 and last round, found=0: candidate -> p_out, found=1 -> FETCH.
REQ-028 DECIDE, pass=1 and last round, found=1: if candidate equals p_out -> discard and FETCH; else candidate -> q_out, pq_valid=1 -> DONE.
REQ-029 DONE: pq_valid, p_out and q_out SHALL hold until the next start.
REQ-030 Minimum latency per odd candidate SHALL be 2 + 3*MR_ROUNDS cycles plus engine time; eng_done in any state other than WAIT SHALL be ignored.
REQ-031 At most one FIFO pop SHALL occur per candidate.

Reset
REQ-032 Assertion of aresetn at any time, including mid-round, SHALL force IDLE immediately.
REQ-033 On reset, all outputs SHALL be 0: rd_en, eng_start, eng_cand, eng_round, p_out, q_out, pq_valid, busy and err_timeout.
REQ-034 Reset SHALL be released synchronously to aclk; the first state change SHALL occur on the first edge after release.

Configuration
REQ-035 Macro PQ_CTRL_TIMEOUT_EN defined: a 16-bit counter SHALL run in WAIT; on reaching TIMEOUT_CYC without eng_done, the candidate SHALL be rejected -> FETCH and err_timeout SHALL set, remaining set until reset.
REQ-036 Macro PQ_CTRL_TIMEOUT_EN undefined: WAIT SHALL be unbounded and err_timeout SHALL be constant 0; the port SHALL remain present.

Verification
REQ-037 Reset with outputs checked all 0 -> start with FIFO empty for 20 cycles -> busy=1, rd_en never asserted.
REQ-038 FIFO 10, 13, 17 with engine always passing, MR_ROUNDS=4 -> 10 popped with no eng_start; p=13, q=17, pq_valid; exactly 8 eng_start pulses.
REQ-039 FIFO 15, 13, 13, 19 with engine failing 15 on round 2 -> 15 gets 3 rounds; duplicate 13 rejected; p=13, q=19.
REQ-040 aresetn dropped in WAIT on the second candidate -> same cycle IDLE, outputs 0; new start completes normally.
REQ-041 With PQ_CTRL_TIMEOUT_EN and TIMEOUT_CYC=8, engine silent on the first candidate -> rejected after 8 cycles, err_timeout=1, next candidate accepted.
REQ-042 start pulsed while in WAIT -> no effect; start in DONE -> pq_valid 0 the next cycle, new search.
